multiword_add_sequencer: RTL

Sequencer that adds or subtracts WORDS*SLICE_W-bit operands one SLICE_W-bit slice per cycle. It uses a single internal slice adder with the same contract as the 16-bit carry-select adder: inputs A, B and Cin, outputs S and Cout. It sits upstream of the slice adder, feeding it operand slices and a registered carry. It also sits downstream of it, collecting S slices into the result and chaining Cout into the next slice. A valid/ready handshake is used on both input and output sides.

---
 rtl/multiword_add_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract sequencer: one SLICE_W-bit slice per cycle
// through a single slice adder, carry chained through a register.
module multiword_add_sequencer #(
  parameter int WORDS   = 4,
  parameter int SLICE_W = 16,
  localparam int W      = WORDS * SLICE_W,
  localparam int IW     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W:0]   add;

  // Slice adder: full SLICE_W+1 result so the carry is never truncated
  assign a_sl = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign b_sl = b_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign add  = {1'b0, a_sl} + {1'b0, b_sl}
              + {{SLICE_W{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = add[SLICE_W-1:0];
        carry_d = add[SLICE_W];
        if (idx_q == LAST) begin
          cout_d  = add[SLICE_W];
          ovf_d   = (a_sl[SLICE_W-1] == b_sl[SLICE_W-1])
                 && (add[SLICE_W-1] != a_sl[SLICE_W-1]);
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule
